// File: rtl/reg_wb_arbiter_if.sv
// Writeback arbiter bus: three register-write requesters, one regfile port.
// global_data carries the spec "global" bus (a reserved word in SV).
interface reg_wb_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  dr0;
  logic [2:0]  dr1;
  logic [2:0]  dr2;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [15:0] data2;
  logic        hold;
  logic [2:0]  ack;
  logic        ld_reg;
  logic [2:0]  DR;
  logic [15:0] global_data;
  logic [7:0]  busy;

  modport master (
    output req, dr0, dr1, dr2,
    output data0, data1, data2, hold,
    input  ack, ld_reg, DR,
    input  global_data, busy
  );

  modport slave (
    input  req, dr0, dr1, dr2,
    input  data0, data1, data2, hold,
    output ack, ld_reg, DR,
    output global_data, busy
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: 3 requesters -> 1 regfile write port, 1-cycle latency.
// Fixed priority 0>1>2 by default; define WB_RR_ARB_EN for round-robin.
module reg_wb_arbiter (
  input logic            clk,
  input logic            reset,
  reg_wb_arbiter_if.slave bus
);
  logic [2:0]  w_gnt;
  logic [2:0]  w_dr;
  logic [15:0] w_data;
  logic [7:0]  w_busy;
  logic        r_ld;
  logic [2:0]  r_dr;
  logic [15:0] r_data;

`ifdef WB_RR_ARB_EN
  logic [1:0] r_ptr;

  // r_ptr is the last granted index; search starts one past it
  always_comb begin
    w_gnt = 3'b000;
    if (!reset && !bus.hold) begin
      case (r_ptr)
        2'd0: begin
          if (bus.req[1])      w_gnt = 3'b010;
          else if (bus.req[2]) w_gnt = 3'b100;
          else if (bus.req[0]) w_gnt = 3'b001;
        end
        2'd1: begin
          if (bus.req[2])      w_gnt = 3'b100;
          else if (bus.req[0]) w_gnt = 3'b001;
          else if (bus.req[1]) w_gnt = 3'b010;
        end
        default: begin
          if (bus.req[0])      w_gnt = 3'b001;
          else if (bus.req[1]) w_gnt = 3'b010;
          else if (bus.req[2]) w_gnt = 3'b100;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 2'd2;
    end else begin
      unique case (1'b1)
        w_gnt[0]: r_ptr <= 2'd0;
        w_gnt[1]: r_ptr <= 2'd1;
        w_gnt[2]: r_ptr <= 2'd2;
        default:  r_ptr <= r_ptr;
      endcase
    end
  end
`else
  always_comb begin
    w_gnt = 3'b000;
    if (!reset && !bus.hold) begin
      if (bus.req[0])      w_gnt = 3'b001;
      else if (bus.req[1]) w_gnt = 3'b010;
      else if (bus.req[2]) w_gnt = 3'b100;
    end
  end
`endif

  always_comb begin
    w_dr   = 3'd0;
    w_data = 16'h0000;
    unique case (1'b1)
      w_gnt[0]: begin w_dr = bus.dr0; w_data = bus.data0; end
      w_gnt[1]: begin w_dr = bus.dr1; w_data = bus.data1; end
      w_gnt[2]: begin w_dr = bus.dr2; w_data = bus.data2; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld   <= 1'b0;
      r_dr   <= 3'd0;
      r_data <= 16'h0000;
    end else begin
      r_ld <= |w_gnt;
      if (|w_gnt) begin
        r_dr   <= w_dr;
        r_data <= w_data;
      end
    end
  end

  always_comb begin
    w_busy = 8'h00;
    if (bus.req[0]) w_busy[bus.dr0] = 1'b1;
    if (bus.req[1]) w_busy[bus.dr1] = 1'b1;
    if (bus.req[2]) w_busy[bus.dr2] = 1'b1;
    if (r_ld)       w_busy[r_dr]    = 1'b1;
  end

  assign bus.ack         = w_gnt;
  assign bus.ld_reg      = r_ld;
  assign bus.DR          = r_dr;
  assign bus.global_data = r_data;
  assign bus.busy        = w_busy;
endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, reset.
REQ-002 Port `clk`, input, 1 bit: clock; all state changes on the rising edge.
REQ-003 Port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 Port `req`, input, 3 bits: req[i] = requester i has a register write pending; held high with dr_i/data_i stable until acked.
REQ-005 Ports `dr0`, `dr1`, `dr2`, input, 3 bits each: destination register of requester 0/1/2.
REQ-006 Ports `data0`, `data1`, `data2`, input, 16 bits each: write data of requester 0/1/2.
REQ-007 Port `hold`, input, 1 bit: freezes granting while high.
REQ-008 Port `ack`, output, 3 bits: one-hot or zero; combinational grant in the arbitration cycle.
REQ-009 Port `ld_reg`, output, 1 bit: registered write strobe to the register file.
REQ-010 Port `DR`, output, 3 bits: registered destination register to the register file.
REQ-011 Port `global`, output, 16 bits: registered write data to the register file.
REQ-012 Port `busy`, output, 8 bits: busy[r] = 1 while register r has a pending or in-flight write.

Function
REQ-013 Arbitration SHALL occur in every cycle in which hold=0 and req!=0; exactly one ack bit SHALL be high in that cycle.
REQ-014 ack SHALL be 3'b000 while hold=1, while req=0, or while reset=1.
REQ-015 ack[i] SHALL only be high when req[i]=1.
REQ-016 On the edge ending a grant cycle for requester i, the block SHALL register ld_reg=1, DR=dr_i and global=data_i.
REQ-017 Write latency SHALL be 1 cycle: ack in cycle N, ld_reg/DR/global valid in cycle N+1, register file updated at the edge ending N+1.
REQ-018 In any cycle with no grant, ld_reg SHALL be 0 on the next cycle; DR and global SHALL hold their last values.
REQ-019 A requester SHALL treat ack[i] as consumed at the same edge; it may present a new request with new data in the following cycle, allowing back-to-back grants (one write per cycle maximum).
REQ-020 In fixed-priority mode, requester 0 > 1 > 2.
REQ-021 busy SHALL be the OR of decode(dr_i) for each req[i]=1, and decode(DR) when ld_reg=1.
REQ-022 Same-DR conflict: two requesters targeting the same DR SHALL be serialised in grant order; the later grant's data SHALL be the final register value.
REQ-023 Raising hold mid-stream SHALL NOT cancel an already registered write; ld_reg for the prior grant SHALL still assert.

Reset
REQ-024 While reset=1: ack=0, ld_reg=0, DR=3'd0, global=16'h0000, round-robin pointer=2 (requester 0 next).
REQ-025 busy SHALL reflect only req/dr inputs during reset, since ld_reg=0.
REQ-026 A grant pending in the cycle reset asserts SHALL be discarded; no write SHALL issue.
REQ-027 Requests held across reset deassertion SHALL be arbitrated in the first cycle after reset.

Configuration
REQ-028 Macro WB_RR_ARB_EN: when defined, arbitration SHALL be round-robin, starting the search at requester (last_grant+1) mod 3.
REQ-029 With WB_RR_ARB_EN, the pointer SHALL update only on a grant.
REQ-030 Without WB_RR_ARB_EN, arbitration SHALL be the fixed priority of REQ-020, with no pointer state.

Verification
REQ-031 Single write: reset, then req=001, dr0=3, data0=16'h1234 for 1 cycle -> ack=001 in that cycle; next cycle ld_reg=1, DR=3, global=16'h1234; busy[3]=1 for both cycles.
REQ-032 Contention, fixed priority: req=111 held three cycles, each requester dropping after its ack -> ack sequence 001, 010, 100; ld_reg high for 3 consecutive cycles.
REQ-033 Contention with WB_RR_ARB_EN: all requesters re-request continuously for 6 cycles -> ack sequence 001, 010, 100, 001, 010, 100.
REQ-034 Hold: req=010 with hold=1 for 4 cycles -> ack=0 and ld_reg=0 throughout; hold drops -> ack=010 in that cycle, ld_reg=1 next cycle.
REQ-035 Same DR: req0 (dr=5, data=16'hAAAA) and req1 (dr=5, data=16'h5555) together, fixed priority -> writes AAAA then 5555 to R5; busy[5] clears after the second ld_reg.
REQ-036 Reset mid-operation: assert reset in the grant cycle of req=100 -> ack=0, and ld_reg=0, DR=0, global=0 the next cycle.
